// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift unit.
// Holds the op encodings, the controller state encoding and the default
// bus / shift-amount widths. It also provides small helpers that decode the
// shift direction and fill type from an op code.
package shift_pkg;

  localparam int BUS_SIZE_DEF   = 32;
  localparam int SHAMT_SIZE_DEF = 5;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_RSV = 2'b10;  // reserved, behaves as SLL
  localparam logic [1:0] OP_SRA = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  // SRL and SRA are the only codes with bit 0 set; SLL and reserved shift left.
  function automatic logic is_right_shift(input logic [1:0] op);
    return op[0];
  endfunction

  function automatic logic is_arith_shift(input logic [1:0] op);
    return (op == OP_SRA);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One logarithmic shift stage (purely combinational).
// Ports:
//   data   - value to shift
//   op     - shift op code (shift_pkg encodings)
//   k      - stage index; the shift distance is 2^k
//   en     - when low the data passes through unchanged
//   result - shifted value
// The arithmetic fill takes the sign from data's MSB. Every arithmetic stage
// preserves the MSB, so this always equals the original operand's sign bit.
module shift_stage
  import shift_pkg::*;
#(
  parameter int BUS_SIZE   = BUS_SIZE_DEF,
  parameter int SHAMT_SIZE = SHAMT_SIZE_DEF
) (
  input  logic [BUS_SIZE-1:0]   data,
  input  logic [1:0]            op,
  input  logic [SHAMT_SIZE-1:0] k,
  input  logic                  en,
  output logic [BUS_SIZE-1:0]   result
);

  logic [SHAMT_SIZE-1:0] amt_s;

  // Select the 2^k shift for the requested op, or pass through when disabled.
  always_comb begin
    amt_s  = {{(SHAMT_SIZE-1){1'b0}}, 1'b1} << k;
    result = data;
    if (!en) begin
      result = data;
    end else if (is_arith_shift(op)) begin
      result = $unsigned($signed(data) >>> amt_s);
    end else if (is_right_shift(op)) begin
      result = data >> amt_s;
    end else begin
      result = data << amt_s;
    end
  end

endmodule

// File: rtl/barrel_shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA controller: applies one log2 shift stage per cycle.
// Ports:
//   i_clk, i_reset_n - clock (rising edge) and async active-low reset
//   i_start          - request, sampled only while o_ready is high
//   i_op             - 00 SLL, 01 SRL, 11 SRA, 10 reserved (as SLL)
//   i_data, i_shamt  - operand and shift amount
//   o_ready          - a start is accepted this cycle (IDLE or DONE)
//   o_busy           - shifting in progress
//   o_done           - one-cycle pulse; o_result is valid
//   o_result         - last result, held until the next result is produced
// Every op takes SHAMT_SIZE shift cycles, whatever the shift amount.
// The working register is separate from o_result, so o_result stays stable
// while the next op is running.
module barrel_shift_sequencer
  import shift_pkg::*;
#(
  parameter int BUS_SIZE   = BUS_SIZE_DEF,
  parameter int SHAMT_SIZE = SHAMT_SIZE_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  input  logic [1:0]            i_op,
  input  logic [BUS_SIZE-1:0]   i_data,
  input  logic [SHAMT_SIZE-1:0] i_shamt,
  output logic                  o_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [BUS_SIZE-1:0]   o_result
);

  localparam logic [SHAMT_SIZE-1:0] LAST_K = SHAMT_SIZE'(SHAMT_SIZE - 1);

  state_e                state_r;
  state_e                state_s;
  logic [SHAMT_SIZE-1:0] k_r;
  logic [SHAMT_SIZE-1:0] shamt_r;
  logic [1:0]            op_r;
  logic [BUS_SIZE-1:0]   work_r;
  logic [BUS_SIZE-1:0]   result_r;
  logic [BUS_SIZE-1:0]   stage_s;
  logic                  accept_s;

  // A single stage is reused every cycle; the counter selects its distance.
  shift_stage #(
    .BUS_SIZE   (BUS_SIZE),
    .SHAMT_SIZE (SHAMT_SIZE)
  ) u_stage (
    .data   (work_r),
    .op     (op_r),
    .k      (k_r),
    .en     (shamt_r[k_r]),
    .result (stage_s)
  );

  // A start is taken in IDLE and also in DONE, which allows back-to-back ops.
  always_comb begin
    accept_s = 1'b0;
    if ((state_r == IDLE) || (state_r == DONE)) begin
      accept_s = i_start;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = i_start ? SHIFT : IDLE;
      SHIFT:   state_s = (k_r == LAST_K) ? DONE : SHIFT;
      DONE:    state_s = i_start ? SHIFT : IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand latch, stage counter, working register and result register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      k_r      <= '0;
      shamt_r  <= '0;
      op_r     <= OP_SLL;
      work_r   <= '0;
      result_r <= '0;
    end else if (accept_s) begin
      k_r     <= '0;
      shamt_r <= i_shamt;
      op_r    <= i_op;
      work_r  <= i_data;
    end else if (state_r == SHIFT) begin
      work_r <= stage_s;
      if (k_r == LAST_K) begin
        k_r      <= '0;
        result_r <= stage_s;
      end else begin
        k_r <= k_r + {{(SHAMT_SIZE-1){1'b0}}, 1'b1};
      end
    end else begin
      work_r <= work_r;
    end
  end

  assign o_ready  = (state_r == IDLE) || (state_r == DONE);
  assign o_busy   = (state_r == SHIFT);
  assign o_done   = (state_r == DONE);
  assign o_result = result_r;

endmodule

// File: tb/tb_barrel_shift_sequencer.sv
module tb_barrel_shift_sequencer;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_start = 1'b0;
  logic [1:0]  i_op = 2'b00;
  logic [31:0] i_data = 32'h0;
  logic [4:0]  i_shamt = 5'd0;
  logic        o_ready;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_result;

  int total = 0;
  int bad = 0;

  barrel_shift_sequencer dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_start   (i_start),
    .i_op      (i_op),
    .i_data    (i_data),
    .i_shamt   (i_shamt),
    .o_ready   (o_ready),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_result  (o_result)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference shift from the op definitions.
  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d,
                                            input logic [4:0] s);
    case (op)
      2'b01:   return d >> s;
      2'b11:   return $unsigned($signed(d) >>> s);
      default: return d << s;
    endcase
  endfunction

  // Model: an accepted op takes 5 busy cycles, then the done cycle carries the result.
  int          m_cnt = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_result = 32'h0;
  logic [31:0] m_pend = 32'h0;

  always @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      m_cnt    <= 0;
      m_done   <= 1'b0;
      m_result <= 32'h0;
    end else if (m_cnt != 0) begin
      m_cnt  <= m_cnt - 1;
      m_done <= (m_cnt == 1);
      if (m_cnt == 1) m_result <= m_pend;
    end else begin
      m_done <= 1'b0;
      if (i_start) begin
        m_cnt  <= 5;
        m_pend <= ref_shift(i_op, i_data, i_shamt);
      end
    end
  end

  always @(negedge i_clk) begin
    chk("cyc_ready", {31'b0, o_ready}, {31'b0, (m_cnt == 0)});
    chk("cyc_busy", {31'b0, o_busy}, {31'b0, (m_cnt != 0)});
    chk("cyc_done", {31'b0, o_done}, {31'b0, m_done});
    chk("cyc_result", o_result, m_result);
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge i_clk);
    #1;
  endtask

  // Issue one op and wait (bounded) for its done pulse; returns in the done cycle.
  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] d,
                        input logic [4:0] s, input logic [31:0] exp);
    int n;
    int busy_n;
    logic got;
    @(negedge i_clk);
    i_op = op; i_data = d; i_shamt = s; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    busy_n = o_busy ? 1 : 0;
    n = 0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge i_clk); #1;
      n++;
      if (o_done) got = 1'b1;
      else if (o_busy) busy_n++;
    end
    chk({nm, "_done_seen"}, {31'b0, got}, 32'd1);
    chk({nm, "_latency"}, n, 32'd5);
    chk({nm, "_busy_cycles"}, busy_n, 32'd5);
    chk({nm, "_result"}, o_result, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dones;
    logic got;
    logic [31:0] res_at_done;

    #2;
    chk("rst_ready", {31'b0, o_ready}, 32'd1);
    chk("rst_busy", {31'b0, o_busy}, 32'd0);
    chk("rst_done", {31'b0, o_done}, 32'd0);
    chk("rst_result", o_result, 32'h0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    idle(2);

    run_op("sll2", 2'b00, 32'hDB6DB6DB, 5'd2, 32'h6DB6DB6C);
    idle(3);
    chk("held_idle", o_result, 32'h6DB6DB6C);
    run_op("sra31", 2'b11, 32'h80000000, 5'd31, 32'hFFFFFFFF);
    idle(1);
    run_op("srl31", 2'b01, 32'h80000000, 5'd31, 32'h00000001);
    idle(1);
    run_op("srl4", 2'b01, 32'hF0F0F0F0, 5'd4, 32'h0F0F0F0F);
    idle(1);
    run_op("shamt0", 2'b11, 32'h12345678, 5'd0, 32'h12345678);
    idle(1);
    run_op("rsv4", 2'b10, 32'h0000000F, 5'd4, 32'h000000F0);
    idle(1);
    run_op("sra_pos", 2'b11, 32'h7FFFFFFF, 5'd4, 32'h07FFFFFF);
    idle(1);

    // Start and operand changes while shifting must be ignored.
    @(negedge i_clk);
    i_op = 2'b01; i_data = 32'hF0F0F0F0; i_shamt = 5'd4; i_start = 1'b1;
    @(posedge i_clk); #1;
    for (int c = 0; c < 3; c++) begin
      i_start = ~i_start;
      i_data = ~i_data;
      i_shamt = i_shamt + 5'd7;
      i_op = ~i_op;
      @(posedge i_clk); #1;
    end
    i_start = 1'b0;
    dones = 0;
    res_at_done = 32'h0;
    for (int c = 0; c < 10; c++) begin
      if (o_done) begin
        dones++;
        res_at_done = o_result;
      end
      @(posedge i_clk); #1;
    end
    chk("ign_done_count", dones, 32'd1);
    chk("ign_result", res_at_done, 32'h0F0F0F0F);

    // Back-to-back: second start issued in the first op's done cycle.
    run_op("b2b_first", 2'b11, 32'h80000000, 5'd31, 32'hFFFFFFFF);
    i_op = 2'b00; i_data = 32'h00000001; i_shamt = 5'd31; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    n = 1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge i_clk); #1;
      n++;
      if (o_done) got = 1'b1;
      else chk("b2b_first_held", o_result, 32'hFFFFFFFF);
    end
    chk("b2b_done_seen", {31'b0, got}, 32'd1);
    chk("b2b_spacing", n, 32'd6);
    chk("b2b_result", o_result, 32'h80000000);
    idle(2);

    // Reset in the third shift cycle aborts the op.
    @(negedge i_clk);
    i_op = 2'b00; i_data = 32'h0000FFFF; i_shamt = 5'd5; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    @(posedge i_clk);
    @(posedge i_clk); #2;
    chk("pre_abort_busy", {31'b0, o_busy}, 32'd1);
    i_reset_n = 1'b0;
    #1;
    chk("abort_ready", {31'b0, o_ready}, 32'd1);
    chk("abort_busy", {31'b0, o_busy}, 32'd0);
    chk("abort_done", {31'b0, o_done}, 32'd0);
    chk("abort_result", o_result, 32'h0);
    dones = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge i_clk); #1;
      if (o_done) dones++;
    end
    @(negedge i_clk);
    i_reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge i_clk); #1;
      if (o_done) dones++;
    end
    chk("abort_no_done", dones, 32'd0);
    run_op("post_rst", 2'b00, 32'h00000003, 5'd1, 32'h00000006);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
